sal_bank_ctrl: RTL and testbench

Per-bank DRAM command legality controller for one bank of the SAL DRAM controller.
- Tracks bank state (closed / open / precharging / refreshing) and the open row.
- Sequences the per-bank saturating timing counters (tRCD, tRAS, tRTP, tWR, tRP, tRFC).
- Publishes per-command ready flags to the scheduler and flags any command issued against them.

---
 rtl/sal_bank_ctrl.sv | 160 ++++++++++++++++
 tb/tb_sal_bank_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sal_bank_ctrl.sv
// Per-bank DRAM command legality controller: bank FSM, timing counters, ready flags.
// Optional auto-precharge (RDA/WRA) is enabled by defining SAL_BANK_AUTO_PRE_EN.
module sal_bank_ctrl #(
  parameter int CNTR_WIDTH = 6,
  parameter int ROW_WIDTH  = 16,
  parameter int T_RCD      = 4,
  parameter int T_RAS      = 10,
  parameter int T_RTP      = 2,
  parameter int T_WR       = 6,
  parameter int T_RP       = 4,
  parameter int T_RFC      = 40
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid_i,
  input  logic [2:0]           cmd_i,
  input  logic [ROW_WIDTH-1:0] row_i,
  output logic                 act_ready_o,
  output logic                 rdwr_ready_o,
  output logic                 pre_ready_o,
  output logic                 ref_ready_o,
  output logic                 row_open_o,
  output logic [ROW_WIDTH-1:0] open_row_o,
  output logic                 err_o,
  output logic                 auto_pre_o
);

  localparam int W = CNTR_WIDTH;
  localparam logic [W-1:0] L_RCD = W'(T_RCD - 1);
  localparam logic [W-1:0] L_RAS = W'(T_RAS - 1);
  localparam logic [W-1:0] L_RTP = W'(T_RTP - 1);
  localparam logic [W-1:0] L_WR  = W'(T_WR - 1);
  localparam logic [W-1:0] L_RP  = W'(T_RP - 1);
  localparam logic [W-1:0] L_RFC = W'(T_RFC - 1);

`ifdef SAL_BANK_AUTO_PRE_EN
  localparam bit AP_EN = 1'b1;
`else
  localparam bit AP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_CLOSED,
    S_OPEN,
    S_PRECH,
    S_REFR
  } state_t;

  state_t               st;
  logic [W-1:0]         rcd, ras, rtp, wr, rp, rfc;
  logic [ROW_WIDTH-1:0] row_q;
  logic                 err_q;
  logic                 ap_pend;

  logic is_act, is_rd, is_wr, is_pre, is_ref, is_rda, is_wra;
  logic idle_ok, act_ok, tmr_clr, ap_fire, rw_ok, pre_ok;
  logic legal, accept;
  logic do_act, do_rd, do_wr, do_pre, do_ref;

  function automatic logic [W-1:0] nxt(
    input logic [W-1:0] c,
    input logic         ld,
    input logic [W-1:0] t
  );
    logic [W-1:0] d;
    d = (c == '0) ? '0 : c - 1'b1;
    return ld ? ((c > t) ? c : t) : d;
  endfunction

  assign is_act = (cmd_i == 3'd0);
  assign is_rd  = (cmd_i == 3'd1);
  assign is_wr  = (cmd_i == 3'd2);
  assign is_pre = (cmd_i == 3'd3);
  assign is_ref = (cmd_i == 3'd4);
  assign is_rda = (cmd_i == 3'd5);
  assign is_wra = (cmd_i == 3'd6);

  assign idle_ok = (st == S_PRECH && rp == '0) ||
                   (st == S_REFR && rfc == '0);
  assign act_ok  = (st == S_CLOSED) || idle_ok;
  assign tmr_clr = (ras == '0) && (rtp == '0) && (wr == '0);
  // Column commands are held off in the cycle the bank precharges itself.
  assign ap_fire = (st == S_OPEN) && ap_pend && tmr_clr;
  assign rw_ok   = (st == S_OPEN) && (rcd == '0) && !ap_fire;
  assign pre_ok  = (st == S_OPEN) && tmr_clr && !ap_pend;

  always_comb begin
    legal = 1'b0;
    unique case (1'b1)
      is_act, is_ref: legal = act_ok;
      is_rd, is_wr:   legal = rw_ok;
      is_pre:         legal = pre_ok;
      is_rda, is_wra: legal = AP_EN && rw_ok;
      default:        legal = 1'b0;
    endcase
  end

  assign accept = cmd_valid_i && legal;
  assign do_act = accept && is_act;
  assign do_rd  = accept && (is_rd || is_rda);
  assign do_wr  = accept && (is_wr || is_wra);
  assign do_pre = accept && is_pre;
  assign do_ref = accept && is_ref;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= S_CLOSED;
      rcd   <= '0;
      ras   <= '0;
      rtp   <= '0;
      wr    <= '0;
      rp    <= '0;
      rfc   <= '0;
      row_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= cmd_valid_i && !legal;
      rcd   <= nxt(rcd, do_act, L_RCD);
      ras   <= nxt(ras, do_act, L_RAS);
      rtp   <= nxt(rtp, do_rd, L_RTP);
      wr    <= nxt(wr, do_wr, L_WR);
      rp    <= nxt(rp, do_pre || ap_fire, L_RP);
      rfc   <= nxt(rfc, do_ref, L_RFC);
      if (do_act) row_q <= row_i;
      unique case (st)
        S_OPEN: begin
          if (do_pre || ap_fire) st <= S_PRECH;
        end
        default: begin
          if (do_act)       st <= S_OPEN;
          else if (do_ref)  st <= S_REFR;
          else if (idle_ok) st <= S_CLOSED;
        end
      endcase
    end
  end

`ifdef SAL_BANK_AUTO_PRE_EN
  logic do_rwa;
  assign do_rwa = accept && (is_rda || is_wra);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ap_pend <= 1'b0;
    else if (ap_fire) ap_pend <= 1'b0;
    else if (do_rwa)  ap_pend <= 1'b1;
  end
`else
  assign ap_pend = 1'b0;
`endif

  assign act_ready_o  = act_ok;
  assign ref_ready_o  = act_ok;
  assign rdwr_ready_o = rw_ok;
  assign pre_ready_o  = pre_ok;
  assign row_open_o   = (st == S_OPEN);
  assign open_row_o   = row_q;
  assign err_o        = err_q;
  assign auto_pre_o   = ap_fire;

endmodule

// File: tb/tb_sal_bank_ctrl.sv
// Self-checking bench for sal_bank_ctrl: cycle-indexed vector table,
// err_o scoreboard queue, and a hand-written asynchronous reset sequence.
module tb_sal_bank_ctrl;

  localparam logic [2:0] ACT = 3'd0;
  localparam logic [2:0] RD  = 3'd1;
  localparam logic [2:0] WR  = 3'd2;
  localparam logic [2:0] PRE = 3'd3;
  localparam logic [2:0] REF = 3'd4;
  localparam logic [2:0] RDA = 3'd5;
  localparam logic [2:0] WRA = 3'd6;
  localparam logic [2:0] RSV = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd = '0;
  logic [15:0] row = '0;
  logic        act_rdy, rw_rdy, pre_rdy, ref_rdy, row_open, err, auto_pre;
  logic [15:0] open_row;

  int checks = 0;
  int fails  = 0;
  logic exp_err_q[$];

  always #5 clk = ~clk;

  sal_bank_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_i        (cmd),
    .row_i        (row),
    .act_ready_o  (act_rdy),
    .rdwr_ready_o (rw_rdy),
    .pre_ready_o  (pre_rdy),
    .ref_ready_o  (ref_rdy),
    .row_open_o   (row_open),
    .open_row_o   (open_row),
    .err_o        (err),
    .auto_pre_o   (auto_pre)
  );

  // exp = {act, rdwr, pre, ref, row_open, auto_pre}
  typedef struct {
    logic        rst;
    int          cyc;
    logic        v;
    logic [2:0]  cmd;
    logic [15:0] row;
    logic        bad;
    logic [5:0]  exp;
    logic [15:0] erow;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic r, input int c, input logic v,
                              input logic [2:0] cm, input logic [15:0] rw,
                              input logic b, input logic [5:0] e,
                              input logic [15:0] er);
    vec_t x;
    x.rst = r; x.cyc = c; x.v = v; x.cmd = cm; x.row = rw;
    x.bad = b; x.exp = e; x.erow = er;
    vt.push_back(x);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd = '0;
    row = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_err_q.delete();
    exp_err_q.push_back(1'b0);
  endtask

  // Called in the negedge window of a cycle: checks err_o, drives, advances.
  task automatic tick(input logic v, input logic [2:0] c,
                      input logic [15:0] r, input logic bad, input int cy);
    logic e;
    e = exp_err_q.pop_front();
    chk($sformatf("err_c%0d", cy), err, e);
    cmd_valid = v;
    cmd = c;
    row = r;
    exp_err_q.push_back(v & bad);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    // A: ACT, tRCD, tRAS, PRE, tRP
    add(1,  0, 1, ACT, 16'h1234, 0, 6'b100100, 16'h0000);
    add(0,  3, 0, ACT, 16'h0,    0, 6'b000010, 16'h1234);
    add(0,  4, 0, ACT, 16'h0,    0, 6'b010010, 16'h1234);
    add(0,  9, 0, ACT, 16'h0,    0, 6'b010010, 16'h1234);
    add(0, 10, 1, PRE, 16'h0,    0, 6'b011010, 16'h1234);
    add(0, 11, 0, ACT, 16'h0,    0, 6'b000000, 16'h1234);
    add(0, 14, 0, ACT, 16'h0,    0, 6'b100100, 16'h1234);
    add(0, 15, 0, ACT, 16'h0,    0, 6'b100100, 16'h1234);
    // B: early PRE is flagged and ignored
    add(1,  0, 1, ACT, 16'hBEEF, 0, 6'b100100, 16'h0000);
    add(0,  4, 1, RD,  16'h0,    0, 6'b010010, 16'hBEEF);
    add(0,  5, 1, PRE, 16'h0,    1, 6'b010010, 16'hBEEF);
    add(0,  6, 0, ACT, 16'h0,    0, 6'b010010, 16'hBEEF);
    add(0, 10, 1, PRE, 16'h0,    0, 6'b011010, 16'hBEEF);
    add(0, 11, 0, ACT, 16'h0,    0, 6'b000000, 16'hBEEF);
    add(0, 13, 0, ACT, 16'h0,    0, 6'b000000, 16'hBEEF);
    add(0, 14, 0, ACT, 16'h0,    0, 6'b100100, 16'hBEEF);
    // C: late WR makes tWR dominate tRAS
    add(1,  0, 1, ACT, 16'h00FF, 0, 6'b100100, 16'h0000);
    add(0,  9, 1, WR,  16'h0,    0, 6'b010010, 16'h00FF);
    add(0, 10, 0, ACT, 16'h0,    0, 6'b010010, 16'h00FF);
    add(0, 14, 0, ACT, 16'h0,    0, 6'b010010, 16'h00FF);
    add(0, 15, 1, PRE, 16'h0,    0, 6'b011010, 16'h00FF);
    add(0, 16, 0, ACT, 16'h0,    0, 6'b000000, 16'h00FF);
    // D: REF and tRFC, illegal ACT during refresh, reserved opcode
    add(1,  0, 1, REF, 16'h0,    0, 6'b100100, 16'h0000);
    add(0,  1, 0, ACT, 16'h0,    0, 6'b000000, 16'h0000);
    add(0, 20, 1, ACT, 16'h7777, 1, 6'b000000, 16'h0000);
    add(0, 21, 0, ACT, 16'h0,    0, 6'b000000, 16'h0000);
    add(0, 39, 0, ACT, 16'h0,    0, 6'b000000, 16'h0000);
    add(0, 40, 1, ACT, 16'h0ABC, 0, 6'b100100, 16'h0000);
    add(0, 41, 1, RSV, 16'h0,    1, 6'b000010, 16'h0ABC);
    add(0, 42, 1, PRE, 16'h0,    1, 6'b000010, 16'h0ABC);
    add(0, 43, 0, ACT, 16'h0,    0, 6'b000010, 16'h0ABC);
    add(0, 44, 0, ACT, 16'h0,    0, 6'b010010, 16'h0ABC);
    // E: RDA / WRA
`ifdef SAL_BANK_AUTO_PRE_EN
    add(1,  0, 1, ACT, 16'h5555, 0, 6'b100100, 16'h0000);
    add(0,  4, 1, RDA, 16'h0,    0, 6'b010010, 16'h5555);
    add(0,  5, 1, RD,  16'h0,    0, 6'b010010, 16'h5555);
    add(0,  8, 1, PRE, 16'h0,    1, 6'b010010, 16'h5555);
    add(0,  9, 0, ACT, 16'h0,    0, 6'b010010, 16'h5555);
    add(0, 10, 0, ACT, 16'h0,    0, 6'b000011, 16'h5555);
    add(0, 11, 0, ACT, 16'h0,    0, 6'b000000, 16'h5555);
    add(0, 14, 0, ACT, 16'h0,    0, 6'b100100, 16'h5555);
`else
    add(1,  0, 1, ACT, 16'h5555, 0, 6'b100100, 16'h0000);
    add(0,  4, 1, RDA, 16'h0,    1, 6'b010010, 16'h5555);
    add(0,  5, 0, ACT, 16'h0,    0, 6'b010010, 16'h5555);
    add(0, 10, 0, ACT, 16'h0,    0, 6'b011010, 16'h5555);
    add(0, 11, 0, ACT, 16'h0,    0, 6'b011010, 16'h5555);
    add(0, 14, 1, WRA, 16'h0,    1, 6'b011010, 16'h5555);
    add(0, 15, 0, ACT, 16'h0,    0, 6'b011010, 16'h5555);
`endif

    cyc = 0;
    @(negedge clk);
    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].rst) begin
        do_reset();
        cyc = 0;
      end
      while (cyc < vt[i].cyc) begin
        tick(1'b0, 3'd0, 16'h0, 1'b0, cyc);
        cyc++;
      end
      chk($sformatf("v%0d_c%0d_flags", i, cyc),
          {act_rdy, rw_rdy, pre_rdy, ref_rdy, row_open, auto_pre},
          vt[i].exp);
      chk($sformatf("v%0d_c%0d_row", i, cyc), open_row, vt[i].erow);
      tick(vt[i].v, vt[i].cmd, vt[i].row, vt[i].bad, cyc);
      cyc++;
    end

    // F: asynchronous reset in the middle of a refresh with err_o pending
    do_reset();
    chk("f_reset_flags", {act_rdy, rw_rdy, pre_rdy, ref_rdy, row_open, err},
        6'b100100);
    tick(1'b1, REF, 16'h0, 1'b0, 0);
    for (int c = 1; c < 9; c++) tick(1'b0, ACT, 16'h0, 1'b0, c);
    tick(1'b1, ACT, 16'h4321, 1'b1, 9);
    chk("f_err_c10", err, 1'b1);
    chk("f_busy_c10", act_rdy, 1'b0);
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("f_async_err", err, 1'b0);
    chk("f_async_act", {act_rdy, ref_rdy, row_open}, 3'b110);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("f_post_flags", {act_rdy, rw_rdy, pre_rdy, ref_rdy, row_open, err},
        6'b100100);
    chk("f_post_row", open_row, 16'h0000);
    @(negedge clk);
    chk("f_post_err", err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
